// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer for the five-stage pipeline: load-use bubble, taken-branch
// flush and counted mult/div freeze, plus a saturating stall-cycle counter.
module hazard_stall_controller #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_RegisterRt,
    input  logic [4:0]  IF_ID_RegisterRs,
    input  logic [4:0]  IF_ID_RegisterRt,
    input  logic        IF_ID_UsesRt,
    input  logic        ID_EX_MultDiv,
    input  logic        EX_BranchTaken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Write,
    output logic        ID_EX_Bubble,
    output logic        EX_MEM_Bubble,
    output logic        MD_Start,
    output logic        Busy,
    output logic [15:0] StallCycles
);

    localparam int unsigned STALL_W = 16;
    localparam logic [CNT_W-1:0]   MD_CNT_INIT = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0]   MD_CNT_LAST = CNT_W'(1);
    localparam logic [STALL_W-1:0] STALL_MAX   = '1;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_md_done;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               w_lu;

    assign w_lu = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                  ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                   (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

    // Pipeline controls depend on the current cycle's hazards, so they are combinational.
    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Bubble = 1'b0;
        MD_Start      = 1'b0;
        Busy          = 1'b0;
        if (!reset) begin
            if (r_state == ST_MD_BUSY) begin
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Bubble = 1'b1;
                Busy          = 1'b1;
            end else if (ID_EX_MultDiv && !r_md_done) begin
                MD_Start      = 1'b1;
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Bubble = 1'b1;
            end else if (EX_BranchTaken) begin
                IF_ID_Flush   = 1'b1;
                ID_EX_Bubble  = 1'b1;
            end else if (w_lu) begin
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Bubble  = 1'b1;
            end
        end
    end

    // md_done lets the finished mult/div leave EX for one RUN cycle without restarting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_md_done   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_md_done <= 1'b0;
                    if (MD_Start) begin
                        r_state <= ST_MD_BUSY;
                        r_cnt   <= MD_CNT_INIT;
                    end
                end
                ST_MD_BUSY: begin
                    r_cnt <= r_cnt - MD_CNT_LAST;
                    if (r_cnt == MD_CNT_LAST) begin
                        r_state   <= ST_RUN;
                        r_md_done <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
            if (!PCWrite && (r_stall_cnt != STALL_MAX))
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign StallCycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (MD_LATENCY=4): load-use, branch
// priority, single and back-to-back mult/div, reset abort and counter saturation.
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_RegisterRt;
    logic [4:0]  IF_ID_RegisterRs;
    logic [4:0]  IF_ID_RegisterRt;
    logic        IF_ID_UsesRt;
    logic        ID_EX_MultDiv;
    logic        EX_BranchTaken;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Write;
    logic        ID_EX_Bubble;
    logic        EX_MEM_Bubble;
    logic        MD_Start;
    logic        Busy;
    logic [15:0] StallCycles;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .IF_ID_UsesRt     (IF_ID_UsesRt),
        .ID_EX_MultDiv    (ID_EX_MultDiv),
        .EX_BranchTaken   (EX_BranchTaken),
        .PCWrite          (PCWrite),
        .IF_ID_Write      (IF_ID_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_EX_Write      (ID_EX_Write),
        .ID_EX_Bubble     (ID_EX_Bubble),
        .EX_MEM_Bubble    (EX_MEM_Bubble),
        .MD_Start         (MD_Start),
        .Busy             (Busy),
        .StallCycles      (StallCycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs the seven control outputs as {PCWrite,IF_ID_Write,IF_ID_Flush,ID_EX_Write,ID_EX_Bubble,EX_MEM_Bubble,MD_Start}.
    function automatic logic [15:0] ctl();
        return {9'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                ID_EX_Bubble, EX_MEM_Bubble, MD_Start};
    endfunction

    task automatic clear_in();
        ID_EX_MemRead    = 1'b0;
        ID_EX_RegisterRt = 5'd0;
        IF_ID_RegisterRs = 5'd0;
        IF_ID_RegisterRt = 5'd0;
        IF_ID_UsesRt     = 1'b0;
        ID_EX_MultDiv    = 1'b0;
        EX_BranchTaken   = 1'b0;
    endtask

    localparam logic [15:0] CTL_IDLE  = 16'b1101000;
    localparam logic [15:0] CTL_LU    = 16'b0001100;
    localparam logic [15:0] CTL_BR    = 16'b1111100;
    localparam logic [15:0] CTL_MDST  = 16'b0000011;
    localparam logic [15:0] CTL_MDBSY = 16'b0000010;

    int starts;
    int first_start;
    int second_start;
    int stalls;

    initial begin
        clear_in();
        reset = 1'b1;
        // Reset with a live load-use hazard: outputs must still be idle.
        @(negedge clk);
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd2; IF_ID_RegisterRs = 5'd2;
        #1 chk("reset_forces_idle", ctl(), CTL_IDLE);
        chk("reset_busy", 16'(Busy), 16'd0);
        @(negedge clk);
        clear_in();
        reset = 1'b0;
        #1 chk("post_reset_ctl", ctl(), CTL_IDLE);
        chk("post_reset_stall", StallCycles, 16'd0);

        // Load-use on rs: exactly one stall cycle.
        @(negedge clk);
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd2; IF_ID_RegisterRs = 5'd2;
        #1 chk("lu_rs", ctl(), CTL_LU);
        @(negedge clk);
        clear_in();
        #1 chk("lu_after_bubble", ctl(), CTL_IDLE);
        chk("lu_stall_cnt", StallCycles, 16'd1);

        // Load into $0 never stalls.
        @(negedge clk);
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd0; IF_ID_RegisterRs = 5'd0;
        #1 chk("lu_rt_zero", ctl(), CTL_IDLE);

        // rt match only counts when the ID instruction reads rt.
        @(negedge clk);
        ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd3; IF_ID_RegisterRt = 5'd5;
        IF_ID_UsesRt = 1'b0;
        #1 chk("lu_rt_unused", ctl(), CTL_IDLE);
        chk("lu_rt0_cnt", StallCycles, 16'd1);
        @(negedge clk);
        IF_ID_UsesRt = 1'b1;
        #1 chk("lu_rt_used", ctl(), CTL_LU);
        @(negedge clk);
        clear_in();
        #1 chk("lu_rt_cnt", StallCycles, 16'd2);

        // Branch beats load-use and does not count as a stall.
        @(negedge clk);
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd2; IF_ID_RegisterRs = 5'd2;
        EX_BranchTaken = 1'b1;
        #1 chk("branch_over_lu", ctl(), CTL_BR);
        @(negedge clk);
        clear_in();
        #1 chk("branch_stall_cnt", StallCycles, 16'd2);

        // Single mult/div held in EX; a branch during MD_BUSY is ignored.
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            ID_EX_MultDiv  = 1'b1;
            EX_BranchTaken = (cyc == 2);
            #1;
            if (cyc == 0) begin
                chk("md_c0_ctl", ctl(), CTL_MDST);
                chk("md_c0_busy", 16'(Busy), 16'd0);
            end else if (cyc < 4) begin
                chk($sformatf("md_c%0d_ctl", cyc), ctl(), CTL_MDBSY);
                chk($sformatf("md_c%0d_busy", cyc), 16'(Busy), 16'd1);
            end else begin
                chk("md_c4_ctl", ctl(), CTL_IDLE);
                chk("md_c4_busy", 16'(Busy), 16'd0);
            end
        end
        @(negedge clk);
        clear_in();
        #1 chk("md_stall_cnt", StallCycles, 16'd6);

        // Back-to-back mult/div: starts 5 cycles apart, 8 stall cycles.
        starts = 0; first_start = -1; second_start = -1; stalls = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            ID_EX_MultDiv = 1'b1;
            #1;
            if (MD_Start) begin
                if (starts == 0) first_start = cyc;
                else if (starts == 1) second_start = cyc;
                starts++;
            end
            if (!PCWrite) stalls++;
        end
        @(negedge clk);
        clear_in();
        #1 chk("b2b_starts", 16'(starts), 16'd2);
        chk("b2b_first", 16'(first_start), 16'd0);
        chk("b2b_second", 16'(second_start), 16'd5);
        chk("b2b_stalls", 16'(stalls), 16'd8);
        chk("b2b_stall_cnt", StallCycles, 16'd14);

        // Reset in the second MD_BUSY cycle aborts the operation.
        @(negedge clk);
        ID_EX_MultDiv = 1'b1;
        #1 chk("rst_md_start", ctl(), CTL_MDST);
        @(negedge clk);
        #1 chk("rst_md_busy1", 16'(Busy), 16'd1);
        @(negedge clk);
        clear_in();
        reset = 1'b1;
        #1 chk("rst_during_busy", 16'(Busy), 16'd0);
        chk("rst_during_ctl", ctl(), CTL_IDLE);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_after_busy", 16'(Busy), 16'd0);
        chk("rst_after_ctl", ctl(), CTL_IDLE);
        chk("rst_after_cnt", StallCycles, 16'd0);

        // Saturation: hold a load-use hazard for 65535 + 5 edges.
        @(negedge clk);
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd7; IF_ID_RegisterRs = 5'd7;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        #1 chk("sat_reach", StallCycles, 16'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 chk("sat_hold", StallCycles, 16'hFFFF);
        chk("sat_still_stalling", ctl(), CTL_LU);
        clear_in();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline hazard and stall sequencer for the five-stage MIPS CPU. It sits beside the forwarding unit, in the ID/EX control path, and covers the hazards forwarding cannot resolve:
- load-use (one-cycle bubble),
- taken branch/jump resolved in EX (flush of younger instructions),
- multi-cycle mult/div occupying EX (counted multi-cycle freeze).

It drives PC, IF/ID, ID/EX and EX/MEM write, flush and bubble controls, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- MD_LATENCY, 4, total EX cycles a mult/div occupies; legal range 2..15
- CNT_W, 4, mult/div down-counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegisterRt  in  5  load destination register
- IF_ID_RegisterRs  in  5  source rs of instruction in ID
- IF_ID_RegisterRt  in  5  source rt of instruction in ID
- IF_ID_UsesRt  in  1  instruction in ID reads rt as a source
- ID_EX_MultDiv  in  1  instruction in EX is mult/div
- EX_BranchTaken  in  1  branch/jump in EX resolved taken
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  clear IF/ID to nop
- ID_EX_Write  out  1  ID/EX register enable
- ID_EX_Bubble  out  1  zero control fields entering ID/EX
- EX_MEM_Bubble  out  1  zero control fields entering EX/MEM
- MD_Start  out  1  one-cycle start pulse to the mult/div unit
- Busy  out  1  FSM in MD_BUSY
- StallCycles  out  16  count of cycles with PCWrite=0, saturating

## Operation
State: FSM {RUN, MD_BUSY}, down-counter `cnt` [CNT_W], flag `md_done`, counter StallCycles. All outputs except StallCycles are combinational from state and inputs.

- **Idle output set:** PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, all flush/bubble outputs=0, MD_Start=0.
- **Load-use condition (LU):** ID_EX_MemRead && ID_EX_RegisterRt!=0 && (ID_EX_RegisterRt==IF_ID_RegisterRs || (IF_ID_UsesRt && ID_EX_RegisterRt==IF_ID_RegisterRt)).
- **RUN priority, highest first:**
  1. ID_EX_MultDiv && !md_done:
     - Outputs: MD_Start=1, PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1.
     - Next: MD_BUSY, cnt=MD_LATENCY-1.
  2. EX_BranchTaken:
     - Outputs: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1 (PC takes target).
     - LU is ignored this cycle.
  3. LU: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  4. Otherwise: idle set.
- **md_done:**
  - In RUN with md_done=1, the finished mult/div advances with no restart.
  - md_done clears at the next edge.
- **MD_BUSY:**
  - Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1, Busy=1.
  - EX_BranchTaken and LU are ignored.
  - cnt decrements each cycle.
  - When cnt==1: next state RUN, md_done=1.
- **StallCycles:** +1 on each edge where PCWrite==0 and reset==0. Holds at 0xFFFF.

## Timing
- **Reset** (sampled at posedge):
  - Next state RUN, cnt=0, md_done=0, StallCycles=0.
  - While reset is high, outputs are forced to the idle set and Busy=0.
  - Reset during MD_BUSY aborts the operation; the first cycle after reset is RUN.
- **Load-use:** exactly 1 stall cycle. After the bubble, ID_EX_MemRead=0, so LU falls without extra state.
- **Mult/div:**
  - Stall length is exactly MD_LATENCY cycles: the entry cycle plus MD_LATENCY-1 MD_BUSY cycles.
  - The instruction leaves EX on the cycle after the last stall.
  - MD_Start is high for 1 cycle only.
- **Branch flush:** 1 cycle, with no state change.
- **Simultaneous events:**
  - Mult/div and branch in the same cycle cannot both be in EX; mult/div wins by priority.
  - Branch beats load-use.
  - A mult/div immediately following another mult/div restarts correctly, because md_done clears after one RUN cycle.

## Test plan
- **Load-use:** lw $2 in EX (MemRead=1, Rt=2), ID Rs=2.
  - Expect PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for 1 cycle.
  - Repeat with Rt=0: no stall.
  - Repeat with rt match and IF_ID_UsesRt=0: no stall.
- **Branch beats load-use:** EX_BranchTaken=1 while LU is true.
  - Expect IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1.
  - StallCycles unchanged.
- **Mult/div, MD_LATENCY=4:** ID_EX_MultDiv=1 held.
  - Expect MD_Start pulse on cycle 0 and PCWrite=0 for cycles 0-3.
  - Busy=1 on cycles 1-3; cycle 4 is idle and MultDiv advances.
  - StallCycles +4.
- **Back-to-back mult/div:** two consecutive mult/div instructions.
  - Expect two MD_Start pulses 5 cycles apart.
  - Expect 8 total stall cycles.
- **Reset mid-operation:** assert reset in the 2nd MD_BUSY cycle.
  - Next cycle: RUN, Busy=0, StallCycles=0, outputs idle.
- **Saturation:** force 65,540 stall cycles.
  - StallCycles holds at 0xFFFF.
